// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - RISC-V memory stage: data-memory request/response FSM and MEM/WB register bundle

package riscv_pkg;
    localparam int XLEN = 32;

    typedef enum logic [4:0] {
        OP_NOP, OP_ADD, OP_ADDI, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL,
        OP_SRA, OP_SLT, OP_SLTU, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW
    } operation_e;
endpackage

module memory_stage
    import riscv_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    input  operation_e      operation_i,
    input  logic [XLEN-1:0] alu_result_i,
    input  logic [XLEN-1:0] store_data_i,
    input  logic [XLEN-1:0] pc_plus4_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            rd_we_i,
    output logic            stall_o,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [3:0]      dmem_wstrb_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    input  logic            dmem_gnt_i,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output logic            wb_valid_o,
    output operation_e      wb_operation_o,
    output logic [XLEN-1:0] wb_pc_plus4_o,
    output logic [XLEN-1:0] wb_rd_data_o,
    output logic [XLEN-1:0] wb_mem_data_o,
    output logic [4:0]      wb_rd_addr_o,
    output logic            wb_rd_we_o,
    output logic            misalign_o
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

    state_e          state_q, state_d;
    operation_e      op_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] store_q;
    logic [XLEN-1:0] pc4_q;
    logic [4:0]      rd_addr_q;
    logic            rd_we_q;

    logic            ex_mem;
    logic            ex_mis;
    logic [3:0]      wstrb_c;
    logic [XLEN-1:0] wdata_c;

    function automatic logic is_load(input operation_e op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction

    function automatic logic is_store(input operation_e op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic logic is_misaligned(input operation_e op, input logic [1:0] lsb);
        logic r;
        case (op)
            OP_LW, OP_SW:         r = (lsb != 2'b00);
            OP_LH, OP_LHU, OP_SH: r = lsb[0];
            default:              r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [XLEN-1:0] extract(input operation_e op, input logic [1:0] lsb,
                                                input logic [XLEN-1:0] rdata);
        logic [7:0]      b;
        logic [15:0]     h;
        logic [XLEN-1:0] r;
        b = 8'(rdata >> {lsb, 3'b000});
        h = lsb[1] ? rdata[31:16] : rdata[15:0];
        case (op)
            OP_LB:   r = {{24{b[7]}}, b};
            OP_LBU:  r = {24'b0, b};
            OP_LH:   r = {{16{h[15]}}, h};
            OP_LHU:  r = {16'b0, h};
            default: r = rdata;
        endcase
        return r;
    endfunction

    assign ex_mem = is_load(operation_i) || is_store(operation_i);
    assign ex_mis = ex_mem && is_misaligned(operation_i, alu_result_i[1:0]);

    // Byte lanes follow the captured address, so the request stays stable while gnt is pending.
    always_comb begin
        wstrb_c = 4'b0000;
        wdata_c = store_q;
        case (op_q)
            OP_SW: wstrb_c = 4'b1111;
            OP_SH: begin
                wstrb_c = 4'b0011 << addr_q[1:0];
                wdata_c = {2{store_q[15:0]}};
            end
            OP_SB: begin
                wstrb_c = 4'b0001 << addr_q[1:0];
                wdata_c = {4{store_q[7:0]}};
            end
            default: ;
        endcase
    end

    assign dmem_addr_o  = {addr_q[31:2], 2'b00};
    assign dmem_wdata_o = wdata_c;
    assign dmem_we_o    = (state_q == REQ) && is_store(op_q);
    assign dmem_wstrb_o = (state_q == REQ) ? wstrb_c : 4'b0000;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        stall_o    = 1'b0;
        dmem_req_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_i && ex_mem && !ex_mis) begin
                    stall_o = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                dmem_req_o = 1'b1;
                stall_o    = 1'b1;
                if (dmem_gnt_i) begin
                    if (is_store(op_q)) begin
                        stall_o = 1'b0;
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                stall_o = 1'b1;
                if (dmem_rvalid_i) begin
                    stall_o = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            op_q      <= OP_NOP;
            addr_q    <= '0;
            store_q   <= '0;
            pc4_q     <= '0;
            rd_addr_q <= '0;
            rd_we_q   <= 1'b0;
        end else if (state_q == IDLE && valid_i && ex_mem && !ex_mis) begin
            op_q      <= operation_i;
            addr_q    <= alu_result_i;
            store_q   <= store_data_i;
            pc4_q     <= pc_plus4_i;
            rd_addr_q <= rd_addr_i;
            rd_we_q   <= rd_we_i;
        end
    end

    // Valid/we/misalign are single-cycle pulses; the data fields hold between completions.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wb_valid_o     <= 1'b0;
            wb_operation_o <= OP_NOP;
            wb_pc_plus4_o  <= '0;
            wb_rd_data_o   <= '0;
            wb_mem_data_o  <= '0;
            wb_rd_addr_o   <= '0;
            wb_rd_we_o     <= 1'b0;
            misalign_o     <= 1'b0;
        end else begin
            wb_valid_o <= 1'b0;
            wb_rd_we_o <= 1'b0;
            misalign_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (valid_i && (!ex_mem || ex_mis)) begin
                        wb_valid_o     <= 1'b1;
                        wb_operation_o <= operation_i;
                        wb_pc_plus4_o  <= pc_plus4_i;
                        wb_rd_data_o   <= alu_result_i;
                        wb_rd_addr_o   <= rd_addr_i;
                        wb_rd_we_o     <= rd_we_i && !ex_mem;
                        misalign_o     <= ex_mis;
                    end
                end
                REQ: begin
                    if (dmem_gnt_i && is_store(op_q)) begin
                        wb_valid_o     <= 1'b1;
                        wb_operation_o <= op_q;
                        wb_pc_plus4_o  <= pc4_q;
                        wb_rd_data_o   <= addr_q;
                        wb_rd_addr_o   <= rd_addr_q;
                    end
                end
                WAIT: begin
                    if (dmem_rvalid_i) begin
                        wb_valid_o     <= 1'b1;
                        wb_operation_o <= op_q;
                        wb_pc_plus4_o  <= pc4_q;
                        wb_rd_data_o   <= addr_q;
                        wb_mem_data_o  <= extract(op_q, addr_q[1:0], dmem_rdata_i);
                        wb_rd_addr_o   <= rd_addr_q;
                        wb_rd_we_o     <= rd_we_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - directed self-checking bench for memory_stage

module tb_memory_stage;
    import riscv_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        valid_i;
    operation_e  operation_i;
    logic [31:0] alu_result_i, store_data_i, pc_plus4_i;
    logic [4:0]  rd_addr_i;
    logic        rd_we_i;
    logic        stall_o, dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic [3:0]  dmem_wstrb_o;
    logic        dmem_gnt_i, dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        wb_valid_o;
    operation_e  wb_operation_o;
    logic [31:0] wb_pc_plus4_o, wb_rd_data_o, wb_mem_data_o;
    logic [4:0]  wb_rd_addr_o;
    logic        wb_rd_we_o, misalign_o;

    int checks = 0;
    int errors = 0;

    memory_stage dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .operation_i(operation_i),
        .alu_result_i(alu_result_i), .store_data_i(store_data_i), .pc_plus4_i(pc_plus4_i),
        .rd_addr_i(rd_addr_i), .rd_we_i(rd_we_i), .stall_o(stall_o),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_wstrb_o(dmem_wstrb_o), .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i),
        .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i), .wb_valid_o(wb_valid_o),
        .wb_operation_o(wb_operation_o), .wb_pc_plus4_o(wb_pc_plus4_o),
        .wb_rd_data_o(wb_rd_data_o), .wb_mem_data_o(wb_mem_data_o),
        .wb_rd_addr_o(wb_rd_addr_o), .wb_rd_we_o(wb_rd_we_o), .misalign_o(misalign_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input operation_e op, input logic [31:0] alu, input logic [31:0] sd,
                         input logic [31:0] pc4, input logic [4:0] rd);
        valid_i      = 1'b1;
        operation_i  = op;
        alu_result_i = alu;
        store_data_i = sd;
        pc_plus4_i   = pc4;
        rd_addr_i    = rd;
        rd_we_i      = 1'b1;
    endtask

    initial begin
        rst_ni = 1'b0; valid_i = 1'b0; operation_i = OP_NOP; alu_result_i = '0;
        store_data_i = '0; pc_plus4_i = '0; rd_addr_i = '0; rd_we_i = 1'b0;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
        tick(); tick();
        rst_ni = 1'b1;
        #1;
        chk("rst_wb_valid", 32'(wb_valid_o), 32'd0);
        chk("rst_wb_we", 32'(wb_rd_we_o), 32'd0);
        chk("rst_misalign", 32'(misalign_o), 32'd0);
        chk("rst_wb_op", 32'(wb_operation_o), 32'd0);
        chk("rst_req", 32'(dmem_req_o), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        tick();

        // ALU op: single-cycle writeback, never stalls
        issue(OP_ADD, 32'h1234, 32'h0, 32'h104, 5'd5);
        #1;
        chk("add_stall", 32'(stall_o), 32'd0);
        chk("add_req", 32'(dmem_req_o), 32'd0);
        tick();
        valid_i = 1'b0;
        chk("add_wb_valid", 32'(wb_valid_o), 32'd1);
        chk("add_rd_data", wb_rd_data_o, 32'h1234);
        chk("add_rd_we", 32'(wb_rd_we_o), 32'd1);
        chk("add_rd_addr", 32'(wb_rd_addr_o), 32'd5);
        chk("add_pc4", wb_pc_plus4_o, 32'h104);
        chk("add_op", 32'(wb_operation_o), 32'(OP_ADD));
        tick();
        chk("idle_wb_valid", 32'(wb_valid_o), 32'd0);
        chk("idle_wb_we", 32'(wb_rd_we_o), 32'd0);

        // stray gnt/rvalid while idle must not produce writeback
        dmem_gnt_i = 1'b1; dmem_rvalid_i = 1'b1;
        tick();
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
        chk("stray_wb_valid", 32'(wb_valid_o), 32'd0);

        // LB at 0x1003, rvalid two cycles after gnt
        issue(OP_LB, 32'h1003, 32'h0, 32'h108, 5'd6);
        #1;
        chk("lb_stall_idle", 32'(stall_o), 32'd1);
        tick();
        valid_i = 1'b0;
        chk("lb_req", 32'(dmem_req_o), 32'd1);
        chk("lb_addr", dmem_addr_o, 32'h1000);
        chk("lb_we", 32'(dmem_we_o), 32'd0);
        chk("lb_wstrb", 32'(dmem_wstrb_o), 32'd0);
        dmem_gnt_i = 1'b1;
        #1;
        chk("lb_stall_gnt", 32'(stall_o), 32'd1);
        tick();
        dmem_gnt_i = 1'b0;
        chk("lb_wait_req", 32'(dmem_req_o), 32'd0);
        chk("lb_wait_stall", 32'(stall_o), 32'd1);
        tick();
        chk("lb_wait_stall2", 32'(stall_o), 32'd1);
        chk("lb_wait_wb_valid", 32'(wb_valid_o), 32'd0);
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h80FF_FF7F;
        #1;
        chk("lb_stall_rvalid", 32'(stall_o), 32'd0);
        tick();
        dmem_rvalid_i = 1'b0;
        chk("lb_wb_valid", 32'(wb_valid_o), 32'd1);
        chk("lb_mem_data", wb_mem_data_o, 32'hFFFF_FF80);
        chk("lb_rd_we", 32'(wb_rd_we_o), 32'd1);
        chk("lb_rd_addr", 32'(wb_rd_addr_o), 32'd6);
        chk("lb_stall_after", 32'(stall_o), 32'd0);

        // SH at 0x2002, gnt delayed 3 cycles; rs2 changes upstream meanwhile
        issue(OP_SH, 32'h2002, 32'hABCD_1234, 32'h10C, 5'd7);
        tick();
        valid_i = 1'b0; store_data_i = 32'h0; alu_result_i = 32'h0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("sh_req", 32'(dmem_req_o), 32'd1);
            chk("sh_we", 32'(dmem_we_o), 32'd1);
            chk("sh_wstrb", 32'(dmem_wstrb_o), 32'hC);
            chk("sh_wdata", dmem_wdata_o, 32'h1234_1234);
            chk("sh_addr", dmem_addr_o, 32'h2000);
            chk("sh_stall", 32'(stall_o), 32'd1);
            tick();
        end
        dmem_gnt_i = 1'b1;
        #1;
        chk("sh_stall_gnt", 32'(stall_o), 32'd0);
        tick();
        dmem_gnt_i = 1'b0;
        chk("sh_wb_valid", 32'(wb_valid_o), 32'd1);
        chk("sh_rd_we", 32'(wb_rd_we_o), 32'd0);
        chk("sh_op", 32'(wb_operation_o), 32'(OP_SH));
        chk("sh_req_after", 32'(dmem_req_o), 32'd0);

        // SB at 0x6001, gnt in the first REQ cycle
        issue(OP_SB, 32'h6001, 32'h0000_00AB, 32'h110, 5'd0);
        tick();
        valid_i = 1'b0;
        dmem_gnt_i = 1'b1;
        #1;
        chk("sb_wstrb", 32'(dmem_wstrb_o), 32'h2);
        chk("sb_wdata", dmem_wdata_o, 32'hABAB_ABAB);
        tick();
        dmem_gnt_i = 1'b0;
        chk("sb_wb_valid", 32'(wb_valid_o), 32'd1);

        // misaligned LW: no request, one-cycle misalign pulse
        issue(OP_LW, 32'h3001, 32'h0, 32'h114, 5'd9);
        #1;
        chk("mis_stall", 32'(stall_o), 32'd0);
        chk("mis_req_idle", 32'(dmem_req_o), 32'd0);
        tick();
        valid_i = 1'b0;
        chk("mis_pulse", 32'(misalign_o), 32'd1);
        chk("mis_wb_valid", 32'(wb_valid_o), 32'd1);
        chk("mis_rd_we", 32'(wb_rd_we_o), 32'd0);
        chk("mis_req", 32'(dmem_req_o), 32'd0);
        tick();
        chk("mis_pulse_end", 32'(misalign_o), 32'd0);
        chk("mis_wb_valid_end", 32'(wb_valid_o), 32'd0);

        // reset while waiting for rvalid; the late rvalid is ignored
        issue(OP_LW, 32'h5000, 32'h0, 32'h118, 5'd10);
        tick();
        valid_i = 1'b0; dmem_gnt_i = 1'b1;
        tick();
        dmem_gnt_i = 1'b0;
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hDEAD_BEEF;
        #1;
        chk("rstw_stall", 32'(stall_o), 32'd0);
        chk("rstw_req", 32'(dmem_req_o), 32'd0);
        tick();
        dmem_rvalid_i = 1'b0;
        chk("rstw_wb_valid", 32'(wb_valid_o), 32'd0);
        chk("rstw_rd_we", 32'(wb_rd_we_o), 32'd0);
        chk("rstw_mem_data", wb_mem_data_o, 32'h0);

        // LHU then ADDI back to back; upstream holds LHU while stalled
        issue(OP_LHU, 32'h4002, 32'h0, 32'h200, 5'd8);
        tick();
        dmem_gnt_i = 1'b1;
        tick();
        dmem_gnt_i = 1'b0;
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hBEEF_0000;
        #1;
        chk("lhu_stall_rvalid", 32'(stall_o), 32'd0);
        tick();
        dmem_rvalid_i = 1'b0;
        issue(OP_ADDI, 32'h55, 32'h0, 32'h204, 5'd9);
        chk("lhu_wb_valid", 32'(wb_valid_o), 32'd1);
        chk("lhu_mem_data", wb_mem_data_o, 32'h0000_BEEF);
        chk("lhu_rd_addr", 32'(wb_rd_addr_o), 32'd8);
        chk("lhu_op", 32'(wb_operation_o), 32'(OP_LHU));
        #1;
        chk("addi_stall", 32'(stall_o), 32'd0);
        tick();
        valid_i = 1'b0;
        chk("addi_wb_valid", 32'(wb_valid_o), 32'd1);
        chk("addi_rd_addr", 32'(wb_rd_addr_o), 32'd9);
        chk("addi_rd_data", wb_rd_data_o, 32'h55);
        chk("addi_op", 32'(wb_operation_o), 32'(OP_ADDI));
        tick();
        chk("nodup_wb_valid", 32'(wb_valid_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
